// File: rtl/mem_dump_reader.sv
// Streams a contiguous window of bram32 words onto a valid/ready interface.
// Optional checksum trailer beat is enabled by defining DUMP_CHECKSUM_EN.
module mem_dump_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_OUT,
    S_CSUM,
    S_FIN
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] remaining;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;
`endif

  // Every output is registered: it is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      remaining <= '0;
`ifdef DUMP_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mem_addr  <= base_addr & ~ADDR_WIDTH'(3);
            remaining <= word_count;
`ifdef DUMP_CHECKSUM_EN
            sum       <= '0;
`endif
            if (word_count == '0) begin
`ifdef DUMP_CHECKSUM_EN
              state   <= S_CSUM;
              busy    <= 1'b1;
              m_valid <= 1'b1;
              m_data  <= '0;
              m_last  <= 1'b1;
`else
              state   <= S_FIN;
              done    <= 1'b1;
`endif
            end else begin
              state     <= S_RD;
              busy      <= 1'b1;
              mem_rd_en <= 1'b1;
            end
          end
        end
        S_RD: state <= S_WAIT;
        S_WAIT: begin
          m_data  <= mem_rd_data;
          m_valid <= 1'b1;
          state   <= S_OUT;
`ifdef DUMP_CHECKSUM_EN
          sum     <= sum + mem_rd_data;
          m_last  <= 1'b0;
`else
          m_last  <= (remaining == CNT_WIDTH'(1));
`endif
        end
        S_OUT: begin
          if (m_ready) begin
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            remaining <= remaining - CNT_WIDTH'(1);
            mem_addr  <= mem_addr + ADDR_WIDTH'(4);
            if (remaining == CNT_WIDTH'(1)) begin
`ifdef DUMP_CHECKSUM_EN
              // sum already includes the final word, captured in WAIT
              state   <= S_CSUM;
              m_valid <= 1'b1;
              m_data  <= sum;
              m_last  <= 1'b1;
`else
              state   <= S_FIN;
              busy    <= 1'b0;
              done    <= 1'b1;
`endif
            end else begin
              state     <= S_RD;
              mem_rd_en <= 1'b1;
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            state   <= S_FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
`endif
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
